pio_bus_master: RTL and testbench
=================================

// Module: pio_bus_master
// PURPOSE
// - Avalon-MM master driving one 8-bit GPIO slave (width reg 0x0, ID reg 0x1, data reg 0x2, output-enable reg 0x4).
// - After reset, probes width and ID, then serves a simple command/response port and optionally polls the pin state.
// - Reports pin edges to fabric logic (e.g. motor/sensor controllers) so they need not speak Avalon.
// PARAMETERS
// - READ_LATENCY  1       cycles from accepted read (read & !waitrequest) to valid readdata; range 1..4
// - POLL_PERIOD   1000    cycles between input polls while poll_en=1; must be >=2
// - WAIT_TIMEOUT  255     max cycles a request is held under waitrequest before abort
// - EXPECT_ID     32'hEA680001  value required from ID register
// PORTS
// - csi_MCLK_clk          in   1   clock
// - rsi_MRST_reset        in   1   reset, synchronous, active-high
// - avm_gpio_address      out  3   word address to slave
// - avm_gpio_writedata    out  32  {24'b0, data}
// - avm_gpio_byteenable   out  4   4'b0001 on write, 4'b1111 on read, 0 when idle
// - avm_gpio_write        out  1   write strobe
// - avm_gpio_read         out  1   read strobe
// - avm_gpio_readdata     in   32  slave read data
// - avm_gpio_waitrequest  in   1   slave stall
// - cmd_valid / cmd_ready in/out 1  command handshake; transfer when both high
// - cmd_write             in   1   1=write, 0=read
// - cmd_address           in   3   target register
// - cmd_wdata             in   8   write byte
// - rsp_valid             out  1   one-cycle pulse: command completed
// - rsp_data              out  8   readdata[7:0] for reads, 0 for writes
// - rsp_err               out  1   valid with rsp_valid: timeout abort
// - poll_en               in   1   enable periodic read of reg 0x2
// - pin_state             out  8   last polled pin value
// - pin_change            out  1   one-cycle pulse when pin_state updated to a different value
// - probe_done / probe_ok out  1   probe finished / width==8 and ID==EXPECT_ID
// BEHAVIOUR
// - Reset: all outputs 0; FSM -> PROBE_W; timer and timeout counters cleared. Reset mid-transfer aborts it, strobes drop next cycle.
// - FSM: PROBE_W -> PROBE_ID -> READY | FAIL; READY -> ISSUE -> (read) RD_WAIT -> READY; (write) -> READY.
// - ISSUE: strobe, address, data, byteenable held constant while waitrequest=1; accepted on first cycle with waitrequest=0, strobe drops next cycle.
// - RD_WAIT: capture readdata exactly READ_LATENCY cycles after acceptance cycle; no new request issued meanwhile.
// - cmd_ready=1 only in READY with probe_ok=1; command registered on handshake, issued next cycle.
// - rsp_valid pulses the cycle after write acceptance or after read capture; never for probe/poll reads.
// - Probe reads reg 0 then reg 1; probe_done=1 after ID capture; probe_ok per rule above; sticky until reset.
// - FAIL: cmd_ready=0, no polling, bus idle until reset.
// - Poll timer counts only in READY with poll_en=1; at expiry sets poll_pend. poll_en=0 clears timer and poll_pend.
// - Arbitration in READY: cmd handshake beats poll_pend; pending poll issues after that command completes.
// - First poll after reset loads pin_state without pin_change; later polls pulse pin_change iff value differs.
// - Timeout: counter reaching WAIT_TIMEOUT under waitrequest drops strobe; command -> rsp_valid+rsp_err, rsp_data=0; poll -> silently dropped, timer restarts; probe -> FAIL.
// STRUCTURE
// - Package pio_pkg: REG_WIDTH=3'd0, REG_ID=3'd1, REG_DATA=3'd2, REG_OE=3'd4, PIO_ID, FSM state enum.
// - Sub-module pio_poll_timer (down-counter + poll_pend flag, clear/enable inputs); rest in one file.
// TESTING
// - Slave returns 8 / 0xEA680001, waitrequest=0 -> probe_done=1, probe_ok=1 within 8 cycles, cmd_ready=1.
// - Slave ID 0x12345678 -> probe_ok=0, cmd_ready stays 0, no further read/write strobes for 2000 cycles.
// - cmd write addr 4 data 0xFF with waitrequest high 3 cycles -> write held 4 cycles, writedata 0x000000FF, be 0001, one rsp_valid.
// - poll_en=1, POLL_PERIOD=16, pins 0x00 then 0x5A -> first poll no pulse, pin_change once with pin_state=0x5A.
// - Command handshake on poll expiry cycle -> command issued first, poll read immediately after; rsp_data correct.
// - waitrequest stuck high on read cmd -> strobe drops after 255 cycles, rsp_valid+rsp_err, cmd_ready returns to 1.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared register map, identity constant and state encodings for the GPIO bus master.
package pio_pkg;

  localparam logic [2:0]  REG_WIDTH = 3'd0;
  localparam logic [2:0]  REG_ID    = 3'd1;
  localparam logic [2:0]  REG_DATA  = 3'd2;
  localparam logic [2:0]  REG_OE    = 3'd4;

  localparam logic [31:0] PIO_ID    = 32'hEA680001;

  typedef enum logic [2:0] {
    ST_PROBE_W,
    ST_PROBE_ID,
    ST_READY,
    ST_ISSUE,
    ST_RD_WAIT,
    ST_FAIL
  } state_e;

  // Who owns the transfer currently on the bus; decides where read data goes.
  typedef enum logic [1:0] {
    REQ_PROBE_W,
    REQ_PROBE_ID,
    REQ_CMD,
    REQ_POLL
  } req_kind_e;

endpackage

// File: rtl/pio_poll_timer.sv
// Poll interval timer: down-counter that raises a sticky pending flag at terminal count.
module pio_poll_timer #(
  parameter int POLL_PERIOD = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic take_i,
  output logic pend_o
);

  localparam int            CW     = $clog2(POLL_PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(POLL_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;

  // Next count: clear wins, otherwise count down and flag a poll at zero.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (clr_i) begin
      cnt_d  = RELOAD;
      pend_d = 1'b0;
    end else begin
      if (take_i) pend_d = 1'b0;
      if (en_i) begin
        if (cnt_q == '0) begin
          cnt_d  = RELOAD;
          pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  // Counter and flag registers; reset means zero elapsed time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= RELOAD;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/pio_bus_master.sv
// Avalon-MM master for one 8-bit GPIO slave: probes the slave after reset, then serves a
// command/response port and optionally polls the pin register, reporting pin edges.
//
// state       | meaning
// ST_PROBE_W  | launch read of width register
// ST_PROBE_ID | launch read of ID register
// ST_READY    | idle; accept a command or start a pending poll
// ST_ISSUE    | strobe on the bus, held until waitrequest drops or timeout
// ST_RD_WAIT  | read accepted, waiting READ_LATENCY cycles for readdata
// ST_FAIL     | probe failed; bus idle until reset
module pio_bus_master
  import pio_pkg::*;
#(
  parameter int          READ_LATENCY = 1,
  parameter int          POLL_PERIOD  = 1000,
  parameter int          WAIT_TIMEOUT = 255,
  parameter logic [31:0] EXPECT_ID    = PIO_ID
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  output logic [2:0]  avm_gpio_address,
  output logic [31:0] avm_gpio_writedata,
  output logic [3:0]  avm_gpio_byteenable,
  output logic        avm_gpio_write,
  output logic        avm_gpio_read,
  input  logic [31:0] avm_gpio_readdata,
  input  logic        avm_gpio_waitrequest,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_address,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  input  logic        poll_en,
  output logic [7:0]  pin_state,
  output logic        pin_change,
  output logic        probe_done,
  output logic        probe_ok
);

  localparam int                 WAIT_CW     = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WAIT_CW-1:0] WAIT_RELOAD = WAIT_CW'(WAIT_TIMEOUT - 1);
  localparam logic [1:0]         LAT_RELOAD  = 2'(READ_LATENCY - 1);

  state_e             state_q, state_d;
  req_kind_e          kind_q, kind_d;
  logic [2:0]         addr_q, addr_d;
  logic [7:0]         wbyte_q, wbyte_d;
  logic               wr_q, wr_d;
  logic [WAIT_CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]         lat_cnt_q, lat_cnt_d;
  logic               width_ok_q, width_ok_d;
  logic               probe_done_q, probe_done_d;
  logic               probe_ok_q, probe_ok_d;
  logic [7:0]         pin_state_q, pin_state_d;
  logic               pin_valid_q, pin_valid_d;
  logic               pin_change_q, pin_change_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic poll_pend, poll_take, poll_restart;
  logic issuing;

  pio_poll_timer #(
    .POLL_PERIOD (POLL_PERIOD)
  ) u_poll_timer (
    .clk_i  (csi_MCLK_clk),
    .rst_i  (rsi_MRST_reset),
    .en_i   (state_q == ST_READY && poll_en),
    .clr_i  (!poll_en || poll_restart),
    .take_i (poll_take),
    .pend_o (poll_pend)
  );

  assign issuing             = (state_q == ST_ISSUE);
  assign avm_gpio_read       = issuing && !wr_q;
  assign avm_gpio_write      = issuing && wr_q;
  assign avm_gpio_address    = issuing ? addr_q : 3'd0;
  assign avm_gpio_writedata  = (issuing && wr_q) ? {24'b0, wbyte_q} : 32'd0;
  assign avm_gpio_byteenable = !issuing ? 4'b0000 : (wr_q ? 4'b0001 : 4'b1111);
  assign cmd_ready           = (state_q == ST_READY) && probe_ok_q;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign pin_state  = pin_state_q;
  assign pin_change = pin_change_q;
  assign probe_done = probe_done_q;
  assign probe_ok   = probe_ok_q;

  // Next-state logic: request launch, bus handshake, timeout and read-data routing.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    addr_d       = addr_q;
    wbyte_d      = wbyte_q;
    wr_d         = wr_q;
    wait_cnt_d   = wait_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    width_ok_d   = width_ok_q;
    probe_done_d = probe_done_q;
    probe_ok_d   = probe_ok_q;
    pin_state_d  = pin_state_q;
    pin_valid_d  = pin_valid_q;
    pin_change_d = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = 1'b0;
    poll_take    = 1'b0;
    poll_restart = 1'b0;

    case (state_q)
      ST_PROBE_W: begin
        kind_d     = REQ_PROBE_W;
        addr_d     = REG_WIDTH;
        wr_d       = 1'b0;
        wbyte_d    = 8'd0;
        wait_cnt_d = WAIT_RELOAD;
        state_d    = ST_ISSUE;
      end
      ST_PROBE_ID: begin
        kind_d     = REQ_PROBE_ID;
        addr_d     = REG_ID;
        wr_d       = 1'b0;
        wbyte_d    = 8'd0;
        wait_cnt_d = WAIT_RELOAD;
        state_d    = ST_ISSUE;
      end
      ST_READY: begin
        // A command handshake in the same cycle as a pending poll goes first.
        if (cmd_valid && cmd_ready) begin
          kind_d     = REQ_CMD;
          addr_d     = cmd_address;
          wr_d       = cmd_write;
          wbyte_d    = cmd_wdata;
          wait_cnt_d = WAIT_RELOAD;
          state_d    = ST_ISSUE;
        end else if (poll_pend) begin
          poll_take  = 1'b1;
          kind_d     = REQ_POLL;
          addr_d     = REG_DATA;
          wr_d       = 1'b0;
          wbyte_d    = 8'd0;
          wait_cnt_d = WAIT_RELOAD;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!avm_gpio_waitrequest) begin
          if (wr_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'd0;
            state_d     = ST_READY;
          end else begin
            lat_cnt_d = LAT_RELOAD;
            state_d   = ST_RD_WAIT;
          end
        end else if (wait_cnt_q == '0) begin
          case (kind_q)
            REQ_CMD: begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = 8'd0;
              state_d     = ST_READY;
            end
            REQ_POLL: begin
              poll_restart = 1'b1;
              state_d      = ST_READY;
            end
            default: state_d = ST_FAIL;
          endcase
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          case (kind_q)
            REQ_PROBE_W: begin
              width_ok_d = (avm_gpio_readdata == 32'd8);
              state_d    = ST_PROBE_ID;
            end
            REQ_PROBE_ID: begin
              probe_done_d = 1'b1;
              probe_ok_d   = width_ok_q && (avm_gpio_readdata == EXPECT_ID);
              state_d      = (width_ok_q && (avm_gpio_readdata == EXPECT_ID)) ? ST_READY : ST_FAIL;
            end
            REQ_CMD: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = avm_gpio_readdata[7:0];
              state_d     = ST_READY;
            end
            default: begin
              // First poll only establishes the baseline; no edge is reported.
              pin_state_d  = avm_gpio_readdata[7:0];
              pin_valid_d  = 1'b1;
              pin_change_d = pin_valid_q && (avm_gpio_readdata[7:0] != pin_state_q);
              state_d      = ST_READY;
            end
          endcase
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_PROBE_W;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state_q      <= ST_PROBE_W;
      kind_q       <= REQ_PROBE_W;
      addr_q       <= 3'd0;
      wbyte_q      <= 8'd0;
      wr_q         <= 1'b0;
      wait_cnt_q   <= '0;
      lat_cnt_q    <= 2'd0;
      width_ok_q   <= 1'b0;
      probe_done_q <= 1'b0;
      probe_ok_q   <= 1'b0;
      pin_state_q  <= 8'd0;
      pin_valid_q  <= 1'b0;
      pin_change_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'd0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      addr_q       <= addr_d;
      wbyte_q      <= wbyte_d;
      wr_q         <= wr_d;
      wait_cnt_q   <= wait_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      width_ok_q   <= width_ok_d;
      probe_done_q <= probe_done_d;
      probe_ok_q   <= probe_ok_d;
      pin_state_q  <= pin_state_d;
      pin_valid_q  <= pin_valid_d;
      pin_change_q <= pin_change_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_pio_bus_master.sv
// Directed bench for pio_bus_master with a behavioural GPIO slave.
module tb_pio_bus_master;

  localparam int POLL_P = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        write, read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_address;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_data;
  logic        poll_en;
  logic [7:0]  pin_state;
  logic        pin_change, probe_done, probe_ok;

  always #5 clk = ~clk;

  pio_bus_master #(
    .READ_LATENCY (1),
    .POLL_PERIOD  (POLL_P),
    .WAIT_TIMEOUT (255),
    .EXPECT_ID    (32'hEA680001)
  ) dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset       (rst),
    .avm_gpio_address     (address),
    .avm_gpio_writedata   (writedata),
    .avm_gpio_byteenable  (byteenable),
    .avm_gpio_write       (write),
    .avm_gpio_read        (read),
    .avm_gpio_readdata    (readdata),
    .avm_gpio_waitrequest (waitrequest),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_write            (cmd_write),
    .cmd_address          (cmd_address),
    .cmd_wdata            (cmd_wdata),
    .rsp_valid            (rsp_valid),
    .rsp_data             (rsp_data),
    .rsp_err              (rsp_err),
    .poll_en              (poll_en),
    .pin_state            (pin_state),
    .pin_change           (pin_change),
    .probe_done           (probe_done),
    .probe_ok             (probe_ok)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave configuration, written only by the main sequence.
  logic [31:0] width_val = 32'd8;
  logic [31:0] id_val    = 32'hEA680001;
  logic [7:0]  pins      = 8'h00;
  bit          stuck     = 1'b0;
  int          wait_cfg  = 0;

  // Slave state and bus observations, written only by the slave process.
  logic [7:0]  oe_reg      = 8'h00;
  logic [31:0] rd_next     = 32'd0;
  bit          rd_pend     = 1'b0;
  int          run         = 0;
  int          last_run    = 0;
  int          strobe_cyc  = 0;
  int          rsp_count   = 0;
  int          pc_count    = 0;
  int          poll_reads  = 0;
  int          ready_cyc   = 0;
  int          acc_n       = 0;
  logic [2:0]  acc_addr [256];
  logic [31:0] last_wdata  = 32'd0;
  logic [3:0]  last_be     = 4'd0;

  function automatic logic [31:0] slave_rd(input logic [2:0] a);
    case (a)
      3'd0:    return width_val;
      3'd1:    return id_val;
      3'd2:    return {24'b0, pins};
      3'd4:    return {24'b0, oe_reg};
      default: return 32'd0;
    endcase
  endfunction

  // Slave: drive at negedge, observe just before the next posedge.
  always begin
    @(negedge clk);
    readdata    = rd_pend ? rd_next : 32'hDEADBEEF;
    rd_pend     = 1'b0;
    waitrequest = (read || write) && (stuck || run < wait_cfg);
    #4;
    if (read || write) begin
      run++;
      strobe_cyc++;
      if (!waitrequest) begin
        if (acc_n < 256) acc_addr[acc_n] = address;
        acc_n++;
        last_be = byteenable;
        if (write) begin
          last_wdata = writedata;
          if (address == 3'd4) oe_reg = writedata[7:0];
        end else begin
          rd_next = slave_rd(address);
          rd_pend = 1'b1;
          if (address == 3'd2) poll_reads++;
        end
      end
    end else if (run > 0) begin
      last_run = run;
      run      = 0;
    end
    if (rsp_valid)  rsp_count++;
    if (pin_change) pc_count++;
    if (cmd_ready)  ready_cyc++;
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_probe(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #4;
      if (probe_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_cmd(input bit w, input logic [2:0] a, input logic [7:0] d, input int max_wait,
                        output bit got, output logic [7:0] rd, output logic er);
    bit hs;
    hs  = 1'b0;
    got = 1'b0;
    rd  = 8'hxx;
    er  = 1'bx;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_write   = w;
    cmd_address = a;
    cmd_wdata   = d;
    for (int i = 0; i < 20; i++) begin
      #4;
      if (cmd_ready) begin
        hs = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      #4;
      if (rsp_valid) begin
        got = hs;
        rd  = rsp_data;
        er  = rsp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit         seen, got, er;
    logic [7:0] rd;
    int         base, r0, p0, s0, q0;

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 3'd0;
    cmd_wdata = 8'd0; poll_en = 1'b0;

    repeat (3) @(negedge clk);
    #4;
    chk("reset_strobes", 32'({read, write, byteenable, address}), 32'd0);
    chk("reset_status", 32'({cmd_ready, rsp_valid, rsp_err, probe_done, probe_ok, pin_change, pin_state}), 32'd0);

    // Good slave: probe completes quickly and opens the command port.
    @(negedge clk);
    rst = 1'b0;
    wait_probe(seen);
    chk("probe_done_in_8", 32'(seen), 32'd1);
    chk("probe_ok", 32'(probe_ok), 32'd1);
    chk("cmd_ready_after_probe", 32'(cmd_ready), 32'd1);

    // Write OE=0xFF under three stall cycles.
    r0 = rsp_count;
    wait_cfg = 3;
    do_cmd(1'b1, 3'd4, 8'hFF, 20, got, rd, er);
    wait_cfg = 0;
    chk("wr_rsp_seen", 32'(got), 32'd1);
    chk("wr_rsp_data", 32'(rd), 32'd0);
    chk("wr_rsp_err", 32'(er), 32'd0);
    repeat (5) @(negedge clk);
    chk("wr_held_cycles", 32'(last_run), 32'd4);
    chk("wr_writedata", last_wdata, 32'h000000FF);
    chk("wr_byteenable", 32'(last_be), 32'd1);
    chk("wr_rsp_count", 32'(rsp_count - r0), 32'd1);

    // Plain reads of ID and width registers.
    do_cmd(1'b0, 3'd1, 8'd0, 20, got, rd, er);
    chk("rd_id_data", 32'({got, er, rd}), 32'h201);
    do_cmd(1'b0, 3'd0, 8'd0, 20, got, rd, er);
    chk("rd_width_data", 32'({got, er, rd}), 32'h208);
    repeat (2) @(negedge clk);
    chk("rd_byteenable", 32'(last_be), 32'hF);

    // Polling: baseline load without a pulse, then one edge report.
    r0 = rsp_count;
    p0 = pc_count;
    q0 = poll_reads;
    pins = 8'h00;
    poll_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (poll_reads != q0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("first_poll_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    chk("first_poll_no_pulse", 32'(pc_count - p0), 32'd0);
    pins = 8'h5A;
    repeat (60) @(negedge clk);
    chk("pin_change_once", 32'(pc_count - p0), 32'd1);
    chk("pin_state_5a", 32'(pin_state), 32'h5A);
    chk("poll_no_rsp", 32'(rsp_count - r0), 32'd0);
    poll_en = 1'b0;
    repeat (5) @(negedge clk);

    // Command handshake exactly on the poll expiry cycle.
    base = acc_n;
    poll_en = 1'b1;
    repeat (14) @(negedge clk);
    do_cmd(1'b0, 3'd4, 8'd0, 20, got, rd, er);
    chk("arb_rsp_data", 32'({got, er, rd}), 32'h2FF);
    repeat (10) @(negedge clk);
    poll_en = 1'b0;
    chk("arb_two_accepts", 32'(acc_n - base >= 2), 32'd1);
    chk("arb_cmd_first", 32'(acc_addr[base]), 32'd4);
    chk("arb_poll_second", 32'(acc_addr[base + 1]), 32'd2);
    repeat (5) @(negedge clk);

    // Read held under a permanently stalled slave.
    stuck = 1'b1;
    do_cmd(1'b0, 3'd2, 8'd0, 300, got, rd, er);
    stuck = 1'b0;
    chk("to_rsp_seen", 32'(got), 32'd1);
    chk("to_rsp_err", 32'(er), 32'd1);
    chk("to_rsp_data", 32'(rd), 32'd0);
    repeat (2) @(negedge clk);
    #4;
    chk("to_strobe_cycles", 32'(last_run), 32'd255);
    chk("to_cmd_ready", 32'(cmd_ready), 32'd1);

    // Wrong ID: probe fails and the bus stays quiet.
    @(negedge clk);
    id_val = 32'h12345678;
    apply_reset();
    wait_probe(seen);
    chk("bad_probe_done", 32'(seen), 32'd1);
    chk("bad_probe_ok", 32'(probe_ok), 32'd0);
    repeat (2) @(negedge clk);
    s0 = strobe_cyc;
    r0 = ready_cyc;
    cmd_valid = 1'b1;
    poll_en   = 1'b1;
    repeat (2000) @(negedge clk);
    cmd_valid = 1'b0;
    poll_en   = 1'b0;
    chk("fail_no_strobes", 32'(strobe_cyc - s0), 32'd0);
    chk("fail_no_cmd_ready", 32'(ready_cyc - r0), 32'd0);
    chk("fail_no_rsp", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
